// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment scan controller with frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZ_BLANK_EN.
module seg7_scan_mux #(
    parameter int PRESCALE = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        en,
    output logic [3:0]  num,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        upd_pending
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pend_q, pend_d;
    logic             upd_q, upd_d;
    logic [3:0]       num_q, num_d;
    logic [3:0]       an_q, an_d;
    logic             tick;
    logic             frame_end;
    logic [3:0]       blank_mask;

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick && (digit_q == 2'd3);

`ifdef SEG7_SCAN_LZ_BLANK_EN
    // A digit goes dark when it and every more significant digit are zero.
    assign blank_mask[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz_blank
            assign blank_mask[gi] = (disp_q[15:4*gi] == '0);
        end
    endgenerate
`else
    assign blank_mask = 4'b0000;
`endif

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        digit_d = tick ? digit_q + 2'd1 : digit_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        upd_d   = upd_q;

        // A load landing on the boundary itself bypasses the pending register.
        if (load && frame_end) begin
            disp_d = value_in;
            upd_d  = 1'b0;
        end else if (load) begin
            pend_d = value_in;
            upd_d  = 1'b1;
        end else if (frame_end && upd_q) begin
            disp_d = pend_q;
            upd_d  = 1'b0;
        end

        num_d = disp_q[{digit_q, 2'b00} +: 4];
        an_d  = en ? (~(4'b0001 << digit_q) | blank_mask) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            digit_q <= 2'd0;
            disp_q  <= 16'h0000;
            pend_q  <= 16'h0000;
            upd_q   <= 1'b0;
            num_q   <= 4'h0;
            an_q    <= 4'b1111;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            upd_q   <= upd_d;
            num_q   <= num_d;
            an_q    <= an_d;
        end
    end

    assign num         = num_q;
    assign an          = an_q;
    assign digit_idx   = digit_q;
    assign upd_pending = upd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux at PRESCALE=4; define SEG7_SCAN_LZ_BLANK_EN to cover blanking.
module tb_seg7_scan_mux;

    localparam int PRE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        en;
    logic [3:0]  num;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        upd_pending;

    seg7_scan_mux #(.PRESCALE(PRE), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load), .en(en),
        .num(num), .an(an), .digit_idx(digit_idx), .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] num;
        logic [3:0] an;
        logic [1:0] didx;
        logic       upd;
    } exp_t;

    typedef struct {
        logic [1:0] slot;
        logic [3:0] num;
        logic [3:0] an;
    } vec_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Reference state: edges since reset release plus the displayed/pending values.
    int          m_cyc = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_upd = 1'b0;

    function automatic logic [3:0] nib(input logic [15:0] v, input int slot);
        logic [15:0] s;
        s = v >> (4 * slot);
        return s[3:0];
    endfunction

    function automatic logic [3:0] blank_of(input logic [15:0] v);
        logic [3:0] b;
        b = 4'b0000;
`ifdef SEG7_SCAN_LZ_BLANK_EN
        if (v[15:12] == 4'h0) b[3] = 1'b1;
        if (v[15:8] == 8'h0)  b[2] = 1'b1;
        if (v[15:4] == 12'h0) b[1] = 1'b1;
`endif
        return b;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, m_cyc, act, exp);
        end
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare after the edge.
    task automatic cycle(input logic r, input logic ld, input logic [15:0] v, input logic e);
        exp_t x;
        int slot;
        logic tick, bnd;
        logic [3:0] one;
        one = 4'b0001;
        rst = r; load = ld; value_in = v; en = e;
        if (r) begin
            x.num = 4'h0; x.an = 4'b1111; x.didx = 2'd0; x.upd = 1'b0;
            m_cyc = 0; m_disp = 16'h0; m_pend = 16'h0; m_upd = 1'b0;
        end else begin
            slot = (m_cyc / PRE) % 4;
            tick = ((m_cyc % PRE) == PRE - 1);
            bnd  = tick && (slot == 3);
            x.num = nib(m_disp, slot);
            x.an  = e ? (~(one << slot) | blank_of(m_disp)) : 4'b1111;
            if (ld && bnd) begin
                m_disp = v; m_upd = 1'b0;
            end else if (ld) begin
                m_pend = v; m_upd = 1'b1;
            end else if (bnd && m_upd) begin
                m_disp = m_pend; m_upd = 1'b0;
            end
            m_cyc++;
            x.didx = 2'((m_cyc / PRE) % 4);
            x.upd  = m_upd;
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("sb_num", {12'h0, num}, {12'h0, x.num});
        chk("sb_an", {12'h0, an}, {12'h0, x.an});
        chk("sb_digit_idx", {14'h0, digit_idx}, {14'h0, x.didx});
        chk("sb_upd_pending", {15'h0, upd_pending}, {15'h0, x.upd});
    endtask

    task automatic idle_until(input int target, input logic e);
        while (m_cyc < target) cycle(1'b0, 1'b0, 16'h0, e);
    endtask

    vec_t tbl[4];

    initial begin
        tbl[0] = '{slot: 2'd0, num: 4'h4, an: 4'b1110};
        tbl[1] = '{slot: 2'd1, num: 4'h3, an: 4'b1101};
        tbl[2] = '{slot: 2'd2, num: 4'h2, an: 4'b1011};
        tbl[3] = '{slot: 2'd3, num: 4'h1, an: 4'b0111};

        rst = 1'b1; load = 1'b0; value_in = 16'h0; en = 1'b1;

        // Reset, with a load attempted underneath it
        cycle(1'b1, 1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1);
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_num", {12'h0, num}, 16'h0000);
        chk("rst_upd", {15'h0, upd_pending}, 16'h0000);

        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("release_an", {12'h0, an}, 16'h000E);
        chk("release_num", {12'h0, num}, 16'h0000);

        // Scan rotation of 1234 over two frames
        cycle(1'b0, 1'b1, 16'h1234, 1'b1);
        chk("load_pending", {15'h0, upd_pending}, 16'h0001);
        idle_until(16, 1'b1);
        chk("apply_clears_pending", {15'h0, upd_pending}, 16'h0000);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++)
                for (int h = 0; h < PRE; h++) begin
                    cycle(1'b0, 1'b0, 16'h0, 1'b1);
                    chk($sformatf("rot_num_s%0d", tbl[i].slot), {12'h0, num}, {12'h0, tbl[i].num});
                    chk($sformatf("rot_an_s%0d", tbl[i].slot), {12'h0, an}, {12'h0, tbl[i].an});
                end

        // Deferred update: ABCD loaded mid-frame shows only after the boundary
        idle_until(54, 1'b1);
        cycle(1'b0, 1'b1, 16'hABCD, 1'b1);
        chk("defer_pending", {15'h0, upd_pending}, 16'h0001);
        idle_until(64, 1'b1);
        chk("defer_old_num", {12'h0, num}, 16'h0001);
        chk("defer_upd_clear", {15'h0, upd_pending}, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("defer_new_num", {12'h0, num}, 16'h000D);
        chk("defer_new_an", {12'h0, an}, 16'h000E);

        // Collision: 00F0 on the boundary tick overrides pending 5555
        idle_until(69, 1'b1);
        cycle(1'b0, 1'b1, 16'h5555, 1'b1);
        chk("coll_pending", {15'h0, upd_pending}, 16'h0001);
        idle_until(79, 1'b1);
        cycle(1'b0, 1'b1, 16'h00F0, 1'b1);
        chk("coll_upd_clear", {15'h0, upd_pending}, 16'h0000);
        for (int i = 0; i < 4 * PRE; i++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b1);
            checks++;
            if (num == 4'h5) begin
                failures++;
                $display("FAIL coll_no5555 cyc=%0d got=%h expected=not 5", m_cyc, num);
            end
        end
        chk("coll_slot0_after_frame", {12'h0, num}, 16'h0000);

        // Enable dropped during slot 2, restored later without phase slip
        idle_until(105, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        chk("en_off_an", {12'h0, an}, 16'h000F);
        idle_until(116, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("en_on_an", {12'h0, an}, 16'h000D);
        chk("en_on_digit", {14'h0, digit_idx}, 16'h0001);

        // Mid-operation reset loses a pending value and clears the display
        cycle(1'b0, 1'b1, 16'h1111, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        chk("midrst_upd", {15'h0, upd_pending}, 16'h0000);
        idle_until(21, 1'b1);
        chk("midrst_num", {12'h0, num}, 16'h0000);

        // Leading-zero cases: 0070, then 0000
        cycle(1'b0, 1'b1, 16'h0070, 1'b1);
        idle_until(33, 1'b1);
        chk("lz70_d0_num", {12'h0, num}, 16'h0000);
        chk("lz70_d0_an", {12'h0, an}, 16'h000E);
        idle_until(37, 1'b1);
        chk("lz70_d1_num", {12'h0, num}, 16'h0007);
        chk("lz70_d1_an", {12'h0, an}, 16'h000D);
        idle_until(41, 1'b1);
`ifdef SEG7_SCAN_LZ_BLANK_EN
        chk("lz70_d2_an", {12'h0, an}, 16'h000F);
`else
        chk("lz70_d2_an", {12'h0, an}, 16'h000B);
`endif
        idle_until(45, 1'b1);
`ifdef SEG7_SCAN_LZ_BLANK_EN
        chk("lz70_d3_an", {12'h0, an}, 16'h000F);
`else
        chk("lz70_d3_an", {12'h0, an}, 16'h0007);
`endif
        cycle(1'b0, 1'b1, 16'h0000, 1'b1);
        idle_until(65, 1'b1);
        chk("lz00_d0_an", {12'h0, an}, 16'h000E);
        idle_until(69, 1'b1);
`ifdef SEG7_SCAN_LZ_BLANK_EN
        chk("lz00_d1_an", {12'h0, an}, 16'h000F);
`else
        chk("lz00_d1_an", {12'h0, an}, 16'h000D);
`endif
        idle_until(80, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
